// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, arbiter FSM states and the default datapath width.
package alu_pkg;

    localparam int WIDTH_DEFAULT = 16;

    typedef enum logic [2:0] {
        ALU_AND  = 3'd0,
        ALU_OR   = 3'd1,
        ALU_NOT  = 3'd2,
        ALU_ADD  = 3'd3,
        ALU_SUB  = 3'd4,
        ALU_RSUB = 3'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= 3'd5);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the port that was not granted last wins.
// Purely combinational; the caller decides when a grant is actually taken.
module rr_arb2 (
    input  logic i_v0,
    input  logic i_v1,
    input  logic i_last_grant,
    output logic o_gnt_id,
    output logic o_gnt_any
);

    assign o_gnt_any = i_v0 | i_v1;
    assign o_gnt_id  = (i_v0 & i_v1) ? ~i_last_grant : i_v1;

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters; legal ops respond 2 cycles after accept, illegal ops 1.
// Response is held until rsp_ready; no request is accepted while an operation is in flight.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic [2:0]       r0_op,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic [2:0]       r1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err
);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_zero;
    logic             r_rsp_err;

    logic             w_gnt_id;
    logic             w_gnt_any;
    logic             w_accept;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [2:0]       w_sel_op;

    rr_arb2 u_rr_arb2 (
        .i_v0         (r0_valid),
        .i_v1         (r1_valid),
        .i_last_grant (r_last_grant),
        .o_gnt_id     (w_gnt_id),
        .o_gnt_any    (w_gnt_any)
    );

    assign w_accept = (r_state == IDLE) & w_gnt_any;
    assign w_sel_a  = w_gnt_id ? r1_a  : r0_a;
    assign w_sel_b  = w_gnt_id ? r1_b  : r0_b;
    assign w_sel_op = w_gnt_id ? r1_op : r0_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_gnt_any) w_state_nxt = is_legal_op(w_sel_op) ? EXEC : RESP;
            EXEC:    w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Ready is masked during reset so nothing looks accepted while state is being cleared.
    always_comb begin
        r0_ready  = 1'b0;
        r1_ready  = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = 3'd0;
        rsp_valid = (r_state == RESP);
        if (rst_n && r_state == IDLE) begin
            r0_ready = w_gnt_any & ~w_gnt_id;
            r1_ready = w_gnt_any &  w_gnt_id;
        end
        if (r_state == EXEC) begin
            alu_a  = r_a;
            alu_b  = r_b;
            alu_op = r_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= 3'd0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a          <= w_sel_a;
                r_b          <= w_sel_b;
                r_op         <= w_sel_op;
                r_rsp_id     <= w_gnt_id;
                r_last_grant <= w_gnt_id;
                if (!is_legal_op(w_sel_op)) begin
                    r_rsp_data <= '0;
                    r_rsp_zero <= 1'b0;
                    r_rsp_err  <= 1'b1;
                end
            end
            if (r_state == EXEC) begin
                r_rsp_data <= alu_out;
                r_rsp_zero <= alu_zero;
                r_rsp_err  <= 1'b0;
            end
        end
    end

    assign rsp_id   = r_rsp_id;
    assign rsp_data = r_rsp_data;
    assign rsp_zero = r_rsp_zero;
    assign rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached to the ALU port.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_valid, r1_valid;
    logic        r0_ready, r1_ready;
    logic [15:0] r0_a, r0_b, r1_a, r1_b;
    logic [2:0]  r0_op, r1_op;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_op;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
    logic [15:0] rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r0_valid  (r0_valid),
        .r0_ready  (r0_ready),
        .r0_a      (r0_a),
        .r0_b      (r0_b),
        .r0_op     (r0_op),
        .r1_valid  (r1_valid),
        .r1_ready  (r1_ready),
        .r1_a      (r1_a),
        .r1_b      (r1_b),
        .r1_op     (r1_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err)
    );

    // Behavioural ALU driven by the arbiter.
    always_comb begin
        case (alu_op)
            3'd0:    alu_out = alu_a & alu_b;
            3'd1:    alu_out = alu_a | alu_b;
            3'd2:    alu_out = ~alu_b;
            3'd3:    alu_out = alu_a + alu_b;
            3'd4:    alu_out = alu_a - alu_b;
            3'd5:    alu_out = alu_b - alu_a;
            default: alu_out = 16'h0000;
        endcase
        alu_zero = (alu_out == 16'h0000);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic resp_ack();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0;
        r0_valid = 1'b1; r1_valid = 1'b1;
        r0_a = '0; r0_b = '0; r0_op = '0;
        r1_a = '0; r1_b = '0; r1_op = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_r0_ready", r0_ready, 0);
        chk("rst_r1_ready", r1_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_zero", rsp_zero, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_op", alu_op, 0);
        r0_valid = 1'b0; r1_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);

        // r0 ADD 3+4
        r0_valid = 1'b1; r0_a = 16'h0003; r0_b = 16'h0004; r0_op = 3'd3; #1;
        chk("add_r0_ready", r0_ready, 1);
        chk("add_r1_ready", r1_ready, 0);
        @(negedge clk); r0_valid = 1'b0;
        chk("add_exec_op", alu_op, 3);
        chk("add_exec_a", alu_a, 16'h0003);
        chk("add_exec_b", alu_b, 16'h0004);
        chk("add_exec_rspv", rsp_valid, 0);
        @(negedge clk);
        chk("add_rspv", rsp_valid, 1);
        chk("add_id", rsp_id, 0);
        chk("add_data", rsp_data, 16'h0007);
        chk("add_zero", rsp_zero, 0);
        chk("add_err", rsp_err, 0);
        chk("add_resp_alu_op", alu_op, 0);
        resp_ack();
        chk("add_done_rspv", rsp_valid, 0);

        // Both valid after a fresh reset: grants alternate 0,1,0,1
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        r0_a = 16'h0005; r0_b = 16'h0005; r0_op = 3'd4;
        r1_a = 16'hF0F0; r1_b = 16'h0F0F; r1_op = 3'd1;
        r0_valid = 1'b1; r1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic e;
            e = (i % 2) == 1;
            #1;
            chk("rr_r0_ready", r0_ready, {31'd0, ~e});
            chk("rr_r1_ready", r1_ready, {31'd0, e});
            @(negedge clk); @(negedge clk);
            chk("rr_rspv", rsp_valid, 1);
            chk("rr_id", rsp_id, {31'd0, e});
            chk("rr_data", rsp_data, e ? 16'hFFFF : 16'h0000);
            chk("rr_zero", rsp_zero, e ? 0 : 1);
            if (i == 3) begin
                r0_valid = 1'b0; r1_valid = 1'b0;
            end
            resp_ack();
        end

        // Illegal opcode from r1
        r1_valid = 1'b1; r1_a = 16'h1234; r1_b = 16'h5678; r1_op = 3'd6; #1;
        chk("ill_r1_ready", r1_ready, 1);
        chk("ill_acc_alu_op", alu_op, 0);
        @(negedge clk); r1_valid = 1'b0;
        chk("ill_rspv", rsp_valid, 1);
        chk("ill_err", rsp_err, 1);
        chk("ill_data", rsp_data, 0);
        chk("ill_zero", rsp_zero, 0);
        chk("ill_id", rsp_id, 1);
        chk("ill_alu_op", alu_op, 0);
        chk("ill_alu_a", alu_a, 0);
        resp_ack();

        // RSUB 10-2 with a stalled consumer and r1 waiting
        r0_valid = 1'b1; r0_a = 16'h0002; r0_b = 16'h000A; r0_op = 3'd5; #1;
        chk("bp_r0_ready", r0_ready, 1);
        @(negedge clk);
        r0_valid = 1'b0;
        r1_valid = 1'b1; r1_a = 16'hFFFF; r1_b = 16'h00FF; r1_op = 3'd0;
        chk("bp_exec_r1_ready", r1_ready, 0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rspv", rsp_valid, 1);
            chk("bp_data", rsp_data, 16'h0008);
            chk("bp_id", rsp_id, 0);
            chk("bp_r1_ready", r1_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1; #1;
        chk("bp_ack_r1_ready", r1_ready, 0);
        @(negedge clk); rsp_ready = 1'b0;
        chk("bp_next_r1_ready", r1_ready, 1);
        @(negedge clk); r1_valid = 1'b0;
        @(negedge clk);
        chk("bp_and_rspv", rsp_valid, 1);
        chk("bp_and_data", rsp_data, 16'h00FF);
        chk("bp_and_id", rsp_id, 1);
        resp_ack();

        // Reset while r0 ADD is executing
        r0_valid = 1'b1; r0_a = 16'h0001; r0_b = 16'h0001; r0_op = 3'd3; #1;
        chk("rx_r0_ready", r0_ready, 1);
        @(negedge clk); r0_valid = 1'b0;
        chk("rx_exec_op", alu_op, 3);
        rst_n = 1'b0; #1;
        chk("rx_rst_alu_op", alu_op, 0);
        chk("rx_rst_rspv", rsp_valid, 0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rx_no_rsp", rsp_valid, 0);
        end
        r0_valid = 1'b1; r1_valid = 1'b1; #1;
        chk("rx_tie_r0_ready", r0_ready, 1);
        chk("rx_tie_r1_ready", r1_ready, 0);
        @(negedge clk); r0_valid = 1'b0; r1_valid = 1'b0;
        @(negedge clk);
        chk("rx_rspv", rsp_valid, 1);
        chk("rx_data", rsp_data, 16'h0002);
        chk("rx_id", rsp_id, 0);
        resp_ack();

        // r0 NOT B=0 three times back to back
        r0_valid = 1'b1; r0_a = 16'h1234; r0_b = 16'h0000; r0_op = 3'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("not_r0_ready", r0_ready, 1);
            @(negedge clk); @(negedge clk);
            chk("not_rspv", rsp_valid, 1);
            chk("not_data", rsp_data, 16'hFFFF);
            chk("not_id", rsp_id, 0);
            chk("not_zero", rsp_zero, 0);
            if (i == 2) r0_valid = 1'b0;
            resp_ack();
        end
        chk("end_idle_rspv", rsp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
